// File: rtl/ex_stage.sv
// EX pipeline stage: ALU, branch target, destination select and a registered EX/MEM bundle.
// Define EX_MULT_EN to enable the 32-iteration shift-add multiply for funct 0x18.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [1:0]  wb_ctl_in,
  input  logic [2:0]  m_ctl_in,
  input  logic        reg_dest,
  input  logic        alu_src,
  input  logic [1:0]  alu_op,
  input  logic [31:0] npc,
  input  logic [31:0] r_data_1,
  input  logic [31:0] r_data_2,
  input  logic [31:0] sign_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic        out_valid,
  output logic [1:0]  wb_ctl_out,
  output logic [2:0]  m_ctl_out,
  output logic [31:0] alu_result,
  output logic [31:0] branch_target,
  output logic [31:0] r_data_2_out,
  output logic        zero,
  output logic [4:0]  write_reg
);

  logic [31:0] w_op_b;
  logic [31:0] w_alu_result;
  logic [31:0] w_branch_target;
  logic        w_accept;
  logic        w_mul_start;

  logic        r_out_valid;
  logic [1:0]  r_wb_ctl;
  logic [2:0]  r_m_ctl;
  logic [31:0] r_alu_result;
  logic [31:0] r_branch_target;
  logic [31:0] r_data_2_q;
  logic        r_zero;
  logic [4:0]  r_write_reg;

  assign w_op_b          = alu_src ? sign_extend : r_data_2;
  assign w_branch_target = npc + {sign_extend[29:0], 2'b00};

  // Single-cycle ALU; funct 0x18 falls to the default and yields 0 here.
  always_comb begin
    w_alu_result = '0;
    case (alu_op)
      2'b00: w_alu_result = r_data_1 + w_op_b;
      2'b01: w_alu_result = r_data_1 - w_op_b;
      2'b10: begin
        case (sign_extend[5:0])
          6'h20:   w_alu_result = r_data_1 + w_op_b;
          6'h22:   w_alu_result = r_data_1 - w_op_b;
          6'h24:   w_alu_result = r_data_1 & w_op_b;
          6'h25:   w_alu_result = r_data_1 | w_op_b;
          6'h2A:   w_alu_result = {31'b0, $signed(r_data_1) < $signed(w_op_b)};
          default: w_alu_result = '0;
        endcase
      end
      default: w_alu_result = '0;
    endcase
  end

`ifdef EX_MULT_EN
  typedef enum logic {StIdle, StMul} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [4:0]  r_count;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [31:0] w_acc_next;
  logic        w_is_mul;
  logic        w_mul_done;

  assign w_is_mul    = (alu_op == 2'b10) && (sign_extend[5:0] == 6'h18);
  assign in_ready    = (r_state == StIdle);
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_mul_start = w_accept && w_is_mul;
  assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
  // Count 31 means this edge performs the 32nd iteration.
  assign w_mul_done  = (r_state == StMul) && !flush && (r_count == 5'd31);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_mul_start) w_state_next = StMul;
      StMul:   if (flush || w_mul_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_mul_start) begin
      r_count  <= '0;
      r_mcand  <= r_data_1;
      r_mplier <= w_op_b;
      r_acc    <= '0;
    end else if (r_state == StMul) begin
      if (flush || w_mul_done) begin
        r_count <= '0;
      end else begin
        r_count  <= r_count + 5'd1;
        r_acc    <= w_acc_next;
        r_mcand  <= {r_mcand[30:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[31:1]};
      end
    end
  end
`else
  assign in_ready    = 1'b1;
  assign w_accept    = in_valid && !flush;
  assign w_mul_start = 1'b0;
`endif

  // Pass-through fields load at accept; a multiply's result and valid follow at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_wb_ctl        <= '0;
      r_m_ctl         <= '0;
      r_alu_result    <= '0;
      r_branch_target <= '0;
      r_data_2_q      <= '0;
      r_zero          <= 1'b0;
      r_write_reg     <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_wb_ctl        <= wb_ctl_in;
        r_m_ctl         <= m_ctl_in;
        r_branch_target <= w_branch_target;
        r_data_2_q      <= r_data_2;
        r_write_reg     <= reg_dest ? instr_1511 : instr_2016;
      end
      if (w_accept && !w_mul_start) begin
        r_alu_result <= w_alu_result;
        r_zero       <= (w_alu_result == 32'd0);
        r_out_valid  <= 1'b1;
      end
`ifdef EX_MULT_EN
      if (w_mul_done) begin
        r_alu_result <= w_acc_next;
        r_zero       <= (w_acc_next == 32'd0);
        r_out_valid  <= 1'b1;
      end
`endif
    end
  end

  assign out_valid     = r_out_valid;
  assign wb_ctl_out    = r_wb_ctl;
  assign m_ctl_out     = r_m_ctl;
  assign alu_result    = r_alu_result;
  assign branch_target = r_branch_target;
  assign r_data_2_out  = r_data_2_q;
  assign zero          = r_zero;
  assign write_reg     = r_write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard of expected EX/MEM bundles vs. observed pulses.
// Multiply checks follow EX_MULT_EN the same way the design does.
`timescale 1ns/1ps
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic [31:0] bt;
    logic [4:0]  wr;
    logic [31:0] rd2;
    logic [1:0]  wb;
    logic [2:0]  m;
  } bundle_t;

  typedef struct packed {
    logic [1:0]  op;
    logic        src;
    logic        rd;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] se;
    logic [4:0]  i20;
    logic [4:0]  i15;
    logic [1:0]  wb;
    logic [2:0]  m;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [1:0]  wb_ctl_in = '0;
  logic [2:0]  m_ctl_in = '0;
  logic        reg_dest = 1'b0;
  logic        alu_src = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [31:0] npc = '0;
  logic [31:0] r_data_1 = '0;
  logic [31:0] r_data_2 = '0;
  logic [31:0] sign_extend = '0;
  logic [4:0]  instr_2016 = '0;
  logic [4:0]  instr_1511 = '0;
  logic        out_valid;
  logic [1:0]  wb_ctl_out;
  logic [2:0]  m_ctl_out;
  logic [31:0] alu_result;
  logic [31:0] branch_target;
  logic [31:0] r_data_2_out;
  logic        zero;
  logic [4:0]  write_reg;

  int n_assert = 0;
  int n_fail = 0;
  bundle_t exp_q[$];
  bundle_t obs_q[$];

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .wb_ctl_in(wb_ctl_in), .m_ctl_in(m_ctl_in), .reg_dest(reg_dest), .alu_src(alu_src),
    .alu_op(alu_op), .npc(npc), .r_data_1(r_data_1), .r_data_2(r_data_2),
    .sign_extend(sign_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
    .out_valid(out_valid), .wb_ctl_out(wb_ctl_out), .m_ctl_out(m_ctl_out),
    .alu_result(alu_result), .branch_target(branch_target), .r_data_2_out(r_data_2_out),
    .zero(zero), .write_reg(write_reg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid)
      obs_q.push_back({alu_result, zero, branch_target, write_reg, r_data_2_out,
                       wb_ctl_out, m_ctl_out});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bundle_t model(input stim_t s);
    bundle_t     e;
    logic [31:0] b;
    logic [31:0] r;
    b = s.src ? s.se : s.b;
    r = 32'd0;
    case (s.op)
      2'b00: r = s.a + b;
      2'b01: r = s.a - b;
      2'b10: begin
        case (s.se[5:0])
          6'h20: r = s.a + b;
          6'h22: r = s.a - b;
          6'h24: r = s.a & b;
          6'h25: r = s.a | b;
          6'h2A: r = ($signed(s.a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EX_MULT_EN
          6'h18: r = s.a * b;
`endif
          default: r = 32'd0;
        endcase
      end
      default: r = 32'd0;
    endcase
    e.res = r;
    e.z   = (r == 32'd0);
    e.bt  = s.npc + (s.se << 2);
    e.wr  = s.rd ? s.i15 : s.i20;
    e.rd2 = s.b;
    e.wb  = s.wb;
    e.m   = s.m;
    return e;
  endfunction

  function automatic stim_t mk(input logic [1:0] op, input logic src, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] se);
    stim_t s;
    s.op  = op;
    s.src = src;
    s.a   = a;
    s.b   = b;
    s.se  = se;
    s.npc = $urandom;
    s.rd  = 1'($urandom_range(0, 1));
    s.i20 = 5'($urandom_range(0, 31));
    s.i15 = 5'($urandom_range(0, 31));
    s.wb  = 2'($urandom_range(0, 3));
    s.m   = 3'($urandom_range(0, 7));
    return s;
  endfunction

  task automatic apply(input stim_t s);
    alu_op = s.op; alu_src = s.src; reg_dest = s.rd; npc = s.npc;
    r_data_1 = s.a; r_data_2 = s.b; sign_extend = s.se;
    instr_2016 = s.i20; instr_1511 = s.i15; wb_ctl_in = s.wb; m_ctl_in = s.m;
    in_valid = 1'b1;
  endtask

  // Drive one op into the accept edge; returns at the falling edge after it.
  task automatic issue(input stim_t s);
    @(negedge clk);
    apply(s);
    exp_q.push_back(model(s));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_assert++;
    if ({out_valid, wb_ctl_out, m_ctl_out, alu_result, branch_target, r_data_2_out, zero,
         write_reg} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b res=%h bt=%h nonzero, required all 0",
               out_valid, alu_result, branch_target);
    end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    bundle_t e, o;
    issue(mk(2'b00, 1'b1, 32'h10, 32'h1234, 32'h4));
    n_assert++;
    if (out_valid !== 1'b1 || alu_result !== 32'h14 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: got v=%b res=%h z=%b required v=1 res=00000014 z=0",
               out_valid, alu_result, zero);
    end
    @(negedge clk);
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_pulse: got out_valid=%b required 0", out_valid);
    end
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL add_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL add_bundle: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_sub_branch();
    bundle_t e, o;
    stim_t   s;
    s = mk(2'b01, 1'b0, 32'h55, 32'h55, 32'hFFFF_FFFF);
    s.npc = 32'h100;
    issue(s);
    n_assert++;
    if (zero !== 1'b1 || branch_target !== 32'hFC) begin
      n_fail++;
      $display("FAIL sub_branch: got z=%b bt=%h required z=1 bt=000000fc", zero, branch_target);
    end
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sub_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL sub_bundle: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_funct();
    bundle_t e, o;
    issue(mk(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0000_002A));
    n_assert++;
    if (alu_result !== 32'h1 || zero !== 1'b0) begin
      n_fail++; $display("FAIL funct_slt: got res=%h z=%b required 00000001 z=0", alu_result, zero);
    end
    issue(mk(2'b10, 1'b0, 32'h0, 32'h1, 32'h0000_0022));
    n_assert++;
    if (alu_result !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL funct_sub: got %h required ffffffff", alu_result);
    end
    issue(mk(2'b10, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0001_0024));
    issue(mk(2'b10, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0002_0025));
    issue(mk(2'b10, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0003_002A));
    issue(mk(2'b10, 1'b0, 32'h1234_5678, 32'h1, 32'h0000_003F));
    issue(mk(2'b11, 1'b0, 32'h1234_5678, 32'h1, 32'h0000_0020));
    n_assert++;
    if (alu_result !== 32'h0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL op11_zero: got res=%h z=%b required 0 z=1", alu_result, zero);
    end
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL funct_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL funct_bundle: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bundle_t     e, o;
    stim_t       s;
    logic [5:0]  fl[5];
    logic [31:0] se;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      se = ($urandom & 32'hFFFF_FFC0) | {26'b0, fl[$urandom_range(0, 4)]};
      s = mk(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom, $urandom, se);
      apply(s);
      exp_q.push_back(model(s));
      n_assert++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready);
      end
      @(negedge clk);
      n_assert++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_valid[%0d]: got %b required 1", i, out_valid);
      end
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_bundle: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef EX_MULT_EN
  task automatic test_mult();
    bundle_t     e, o;
    logic [31:0] ma[2];
    logic [31:0] mb[2];
    logic [31:0] mr[2];
    int          lat;
    bit          early_ready;
    ma = '{32'd7, 32'hFFFF_FFFF};
    mb = '{32'd6, 32'd2};
    mr = '{32'd42, 32'hFFFF_FFFE};
    for (int k = 0; k < 2; k++) begin
      issue(mk(2'b10, 1'b0, ma[k], mb[k], 32'h0040_0018));
      n_assert++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_start[%0d]: got ready=%b valid=%b required 0 0", k, in_ready, out_valid);
      end
      lat = 0;
      early_ready = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (out_valid) begin lat = c; break; end
        if (in_ready) early_ready = 1'b1;
      end
      n_assert++;
      if (lat != 32 || early_ready) begin
        n_fail++;
        $display("FAIL mul_latency[%0d]: got %0d cycles early_ready=%b required 32 and 0",
                 k, lat, early_ready);
      end
      n_assert++;
      if (alu_result !== mr[k] || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_result[%0d]: got %h ready=%b required %h ready=1",
                 k, alu_result, in_ready, mr[k]);
      end
      @(negedge clk);
      n_assert++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL mul_pulse[%0d]: got %b required 0", k, out_valid);
      end
    end
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL mul_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL mul_bundle: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`else
  task automatic test_mult();
    bundle_t e, o;
    issue(mk(2'b10, 1'b0, 32'd7, 32'd6, 32'h0040_0018));
    n_assert++;
    if (out_valid !== 1'b1 || alu_result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_off: got v=%b res=%h z=%b rdy=%b required 1 0 1 1",
               out_valid, alu_result, zero, in_ready);
    end
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL muloff_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL muloff_bundle: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  task automatic test_flush();
    bundle_t e, o;
    int      seen;
    // Flush with in_valid high at an idle edge: nothing is accepted.
    @(negedge clk);
    apply(mk(2'b00, 1'b0, 32'h1, 32'h2, 32'h0));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got out_valid=%b required 0", out_valid);
    end
`ifdef EX_MULT_EN
    issue(mk(2'b10, 1'b0, 32'd7, 32'd6, 32'h0000_0018));
    void'(exp_q.pop_back());
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_assert++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mul: got ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
`endif
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_assert++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_silent: got %0d pulses required 0", seen);
    end
    obs_q.delete();
    issue(mk(2'b00, 1'b0, 32'h3000_0000, 32'h0000_0abc, 32'h10));
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL flush_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL flush_bundle: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    bundle_t e, o;
    issue(mk(2'b00, 1'b0, 32'hDEAD_0000, 32'h0000_BEEF, 32'h7));
    n_assert++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got out_valid=%b required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({out_valid, wb_ctl_out, m_ctl_out, alu_result, branch_target, r_data_2_out, zero,
         write_reg} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_outputs: got res=%h bt=%h rd2=%h rdy=%b required all 0 rdy=1",
               alu_result, branch_target, r_data_2_out, in_ready);
    end
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(2'b01, 1'b1, 32'h100, 32'h55, 32'h40));
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL arst_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL arst_bundle: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_branch();
    test_funct();
    test_back_to_back();
    test_mult();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
